// File: rtl/dual_regfile.sv
// Integer (GPR) and floating-point (FPR) register files for the single-cycle DLX datapath.
// Reads are combinational with no write bypass; writes commit on the rising edge; gpr[0] is hardwired to zero.
module dual_regfile #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  input  logic [AW-1:0]      rd,
  input  logic               regWr,
  input  logic [0:WIDTH-1]   busW,
  input  logic [AW-1:0]      frs1,
  input  logic [AW-1:0]      frs2,
  input  logic [AW-1:0]      frd,
  input  logic               fregWr,
  input  logic [0:WIDTH-1]   fbusW,
  output logic [0:WIDTH-1]   busA,
  output logic [0:WIDTH-1]   busB,
  output logic [0:WIDTH-1]   fbusA,
  output logic [0:WIDTH-1]   fbusB
);

  localparam int DEPTH = 2 ** AW;

  logic [0:WIDTH-1] gpr [DEPTH];
  logic [0:WIDTH-1] fpr [DEPTH];

  // Reset wins over both write ports; gpr[0] is never written so it stays at the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr[i] <= '0;
        fpr[i] <= '0;
      end
    end else begin
      if (regWr && (rd != '0)) begin
        gpr[rd] <= busW;
      end
      if (fregWr) begin
        fpr[frd] <= fbusW;
      end
    end
  end

  // The r0 read mask keeps busA/busB at zero even before the first reset.
  assign busA  = (rs1 == '0) ? '0 : gpr[rs1];
  assign busB  = (rs2 == '0) ? '0 : gpr[rs2];
  assign fbusA = fpr[frs1];
  assign fbusB = fpr[frs2];

endmodule

// File: tb/tb_dual_regfile.sv
// Directed self-checking bench for dual_regfile: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge that commits writes.
module tb_dual_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, frs1, frs2, frd;
  logic        regWr, fregWr;
  logic [0:31] busW, fbusW;
  logic [0:31] busA, busB, fbusA, fbusB;

  int n_cmp;
  int n_err;

  dual_regfile #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .rs1(rs1), .rs2(rs2), .rd(rd), .regWr(regWr), .busW(busW),
    .frs1(frs1), .frs2(frs2), .frd(frd), .fregWr(fregWr), .fbusW(fbusW),
    .busA(busA), .busB(busB), .fbusA(fbusA), .fbusB(fbusB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_writes();
    regWr  = 1'b0;
    fregWr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; rs2 = i[4:0]; frs1 = i[4:0]; frs2 = i[4:0];
      #1;
      n_cmp++;
      if (busA !== 32'h0 || busB !== 32'h0 || fbusA !== 32'h0 || fbusB !== 32'h0) begin
        n_err++;
        $display("FAIL reset_state addr=%0d busA=%h busB=%h fbusA=%h fbusB=%h required all 0",
                 i, busA, busB, fbusA, fbusB);
      end
    end
  endtask

  task automatic test_reset_clear();
    @(negedge clk);
    regWr = 1'b1; rd = 5'd5; busW = 32'hDEADBEEF;
    fregWr = 1'b1; frd = 5'd7; fbusW = 32'h12345678;
    @(negedge clk);
    idle_writes();
    rs1 = 5'd5; frs1 = 5'd7;
    #1;
    n_cmp++;
    if (busA !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL preload_gpr5 got=%h required=deadbeef", busA);
    end
    n_cmp++;
    if (fbusA !== 32'h12345678) begin
      n_err++; $display("FAIL preload_fpr7 got=%h required=12345678", fbusA);
    end
    @(negedge clk);
    reset = 1'b1; regWr = 1'b1; rd = 5'd5; busW = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0; idle_writes();
    #1;
    n_cmp++;
    if (busA !== 32'h0) begin
      n_err++; $display("FAIL reset_clear_gpr5 got=%h required=00000000", busA);
    end
    n_cmp++;
    if (fbusA !== 32'h0) begin
      n_err++; $display("FAIL reset_clear_fpr7 got=%h required=00000000", fbusA);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    rs1 = 5'd3; rs2 = 5'd3;
    regWr = 1'b1; rd = 5'd3; busW = 32'h0000002A;
    #1;
    n_cmp++;
    if (busA !== 32'h0) begin
      n_err++; $display("FAIL no_bypass_gpr3 got=%h required=00000000", busA);
    end
    @(negedge clk);
    idle_writes();
    #1;
    n_cmp++;
    if (busA !== 32'h2A || busB !== 32'h2A) begin
      n_err++; $display("FAIL basic_rw_gpr3 busA=%h busB=%h required=0000002a", busA, busB);
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    regWr = 1'b1; rd = 5'd0; busW = 32'hFFFFFFFF;
    fregWr = 1'b1; frd = 5'd0; fbusW = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0; frs1 = 5'd0;
    @(negedge clk);
    idle_writes();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (busA !== 32'h0 || busB !== 32'h0) begin
        n_err++; $display("FAIL r0_hardwire cyc=%0d busA=%h busB=%h required=00000000", c, busA, busB);
      end
      n_cmp++;
      if (fbusA !== 32'hFFFFFFFF) begin
        n_err++; $display("FAIL fpr0_writable cyc=%0d got=%h required=ffffffff", c, fbusA);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    regWr = 1'b1; rd = 5'd9; busW = 32'h11111111;
    fregWr = 1'b1; frd = 5'd9; fbusW = 32'h22222222;
    @(negedge clk);
    idle_writes();
    rs1 = 5'd9; frs1 = 5'd9;
    #1;
    n_cmp++;
    if (busA !== 32'h11111111) begin
      n_err++; $display("FAIL dual_write_gpr9 got=%h required=11111111", busA);
    end
    n_cmp++;
    if (fbusA !== 32'h22222222) begin
      n_err++; $display("FAIL dual_write_fpr9 got=%h required=22222222", fbusA);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rs2 = 5'd31;
    regWr = 1'b1; rd = 5'd31; busW = 32'h1;
    #1;
    n_cmp++;
    if (busB !== 32'h0) begin
      n_err++; $display("FAIL b2b_cyc0 got=%h required=00000000", busB);
    end
    @(negedge clk);
    busW = 32'h2;
    #1;
    n_cmp++;
    if (busB !== 32'h1) begin
      n_err++; $display("FAIL b2b_cyc1 got=%h required=00000001", busB);
    end
    @(negedge clk);
    idle_writes();
    #1;
    n_cmp++;
    if (busB !== 32'h2) begin
      n_err++; $display("FAIL b2b_cyc2 got=%h required=00000002", busB);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] eg, ef, eg2, ef2;
    int j;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      regWr = 1'b1; rd = i[4:0]; busW = i * 32'h01010101;
      fregWr = 1'b1; frd = i[4:0]; fbusW = ~i;
    end
    @(negedge clk);
    idle_writes();
    for (int i = 0; i < 32; i++) begin
      j = 31 - i;
      rs1 = i[4:0]; frs1 = i[4:0]; rs2 = j[4:0]; frs2 = j[4:0];
      eg  = (i == 0) ? 32'h0 : i * 32'h01010101;
      eg2 = (j == 0) ? 32'h0 : j * 32'h01010101;
      ef  = ~i;  // fpr[0] holds ffffffff from the r0 test, which equals ~0
      ef2 = ~j;
      #1;
      n_cmp++;
      if (busA !== eg || busB !== eg2) begin
        n_err++; $display("FAIL sweep_gpr a=%0d busA=%h req=%h b=%0d busB=%h req=%h", i, busA, eg, j, busB, eg2);
      end
      n_cmp++;
      if (fbusA !== ef || fbusB !== ef2) begin
        n_err++; $display("FAIL sweep_fpr a=%0d fbusA=%h req=%h b=%0d fbusB=%h req=%h", i, fbusA, ef, j, fbusB, ef2);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; frs1 = '0; frs2 = '0; frd = '0;
    regWr = 1'b0; fregWr = 1'b0; busW = '0; fbusW = '0;
    test_reset();
    test_reset_clear();
    test_basic();
    test_r0();
    test_dual_write();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_regfile.md
Name: dual_regfile

Overview:
- Integer and floating-point register file for the single-cycle DLX datapath.
- Sits directly upstream of the ALU/FPU stage and drives its busA/busB (integer) and fbusA/fbusB (FP) operand buses.
- Accepts one integer writeback and one FP writeback per cycle from the writeback mux.
- Reads are combinational; writes commit on the rising clock edge, which gives single-cycle read-modify-write semantics.

Parameters:
- WIDTH, 32, data width of every register and bus.
- AW, 5, register address width (2**AW registers per file).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rs1  input  AW  integer read port A address.
- rs2  input  AW  integer read port B address.
- rd  input  AW  integer write address.
- regWr  input  1  integer write enable.
- busW  input  WIDTH  integer write data.
- frs1  input  AW  FP read port A address.
- frs2  input  AW  FP read port B address.
- frd  input  AW  FP write address.
- fregWr  input  1  FP write enable.
- fbusW  input  WIDTH  FP write data.
- busA  output  WIDTH  contents of integer register rs1.
- busB  output  WIDTH  contents of integer register rs2.
- fbusA  output  WIDTH  contents of FP register frs1.
- fbusB  output  WIDTH  contents of FP register frs2.

All buses are numbered [0:WIDTH-1], with bit 0 as the MSB, matching the ALU/FPU operand buses.

Behaviour:
- Storage: two arrays, gpr[0..2**AW-1] and fpr[0..2**AW-1], each WIDTH bits.
- Reset:
  - reset=1 at a rising edge clears every gpr and fpr entry to 0.
  - During reset, all four read outputs therefore read 0 from the next cycle on.
  - reset has priority over regWr/fregWr in the same cycle, so a write asserted with reset is discarded.
  - Reset asserted mid-program: all writes pending that cycle are lost and the register contents are 0 after the edge.
- Write:
  - At a rising edge with reset=0 and regWr=1, gpr[rd] <= busW.
  - At a rising edge with reset=0 and fregWr=1, fpr[frd] <= fbusW.
  - The two write ports are independent; both may fire in the same cycle, even with rd==frd.
- r0 rule:
  - gpr[0] is hardwired to 0. A write with rd=0 is ignored, and busA/busB read 0 whenever rs1/rs2=0.
  - fpr[0] is an ordinary writable register; there is no hardwiring in the FP file.
- Read:
  - busA = gpr[rs1], busB = gpr[rs2], fbusA = fpr[frs1], fbusB = fpr[frs2]. All are purely combinational from the addresses and stored state.
  - There is no write-to-read bypass. In the cycle a write is enabled, reads of the same address return the old value; the new value is visible immediately after the edge.
  - Both read ports may address the same register and return identical data.
- Latency: read 0 cycles (combinational); write 1 edge.
- No X propagation:
  - Every entry is defined after the first reset edge.
  - Before the first reset, contents are unspecified. The bench must apply reset first.
- Unknown or X enables are not required to be handled.

Test Plan:
- Reset clear: preload via writes gpr[5]=0xDEADBEEF and fpr[7]=0x12345678, assert reset for 1 cycle with regWr=1, rd=5, busW=0xFFFFFFFF -> after the edge busA(rs1=5)=0 and fbusA(frs1=7)=0; the write is discarded.
- Basic write/read: regWr=1, rd=3, busW=0x0000002A; next cycle rs1=3, rs2=3 -> busA=busB=0x0000002A. In the write cycle itself busA(rs1=3) still shows the old value 0.
- r0 hardwire: regWr=1, rd=0, busW=0xFFFFFFFF -> busA(rs1=0)=0 on every following cycle. fregWr=1, frd=0, fbusW=0xFFFFFFFF -> fbusA(frs1=0)=0xFFFFFFFF.
- Dual write same cycle: regWr=1, rd=9, busW=0x11111111 together with fregWr=1, frd=9, fbusW=0x22222222 -> busA(rs1=9)=0x11111111 and fbusA(frs1=9)=0x22222222; the files are independent.
- Back-to-back overwrite: cycle n writes gpr[31]=0x1, cycle n+1 writes gpr[31]=0x2, with rs2=31 held -> busB reads 0, then 0x1, then 0x2 across the three cycles following the start.
- Sweep: write gpr[i]=i*0x01010101 and fpr[i]=~i for i=1..31, then read every address on both ports of both files -> all values match and gpr[0]=0.
